// File: rtl/router_pkg.sv
// Shared types and header helpers for the router ingress feeder.
package router_pkg;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PLD,
    ST_PAD,
    ST_DISCARD,
    ST_DTAIL,
    ST_PAR,
    ST_GAP
  } state_t;

  function automatic logic [LEN_W-1:0] hdr_len(input logic [7:0] hdr);
    return hdr[7:2];
  endfunction

  function automatic logic [ADDR_W-1:0] hdr_addr(input logic [7:0] hdr);
    return hdr[1:0];
  endfunction

  // A header the router can deliver: real output port and non-empty payload.
  function automatic logic hdr_routable(input logic [7:0] hdr);
    return (hdr_addr(hdr) != ADDR_INVALID) && (hdr_len(hdr) != '0);
  endfunction

endpackage

// File: rtl/router_hold_reg.sv
// One-entry output hold register facing the router. The entry is taken
// when it is full and the router is not busy; while busy it stays frozen.
module router_hold_reg
  import router_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [7:0] i_load_data,
  input  logic       i_load_pv,
  input  logic       i_busy,
  output logic       o_full,
  output logic [7:0] o_data,
  output logic       o_pv,
  output logic       o_take
);

  logic       r_full;
  logic [7:0] r_data;
  logic       r_pv;

  assign o_take = r_full & ~i_busy;
  assign o_full = r_full;
  assign o_data = r_data;
  assign o_pv   = r_pv;

  // Load has priority; a take with no reload empties the entry. Data and
  // pv are kept when empty so the router pins never glitch.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_full <= 1'b0;
      r_data <= 8'h00;
      r_pv   <= 1'b0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_data <= i_load_data;
      r_pv   <= i_load_pv;
    end else if (o_take) begin
      r_full <= 1'b0;
    end
  end

endmodule

// File: rtl/router_pkt_ingress.sv
// Ingress feeder for the 1x3 router: forwards header and payload, enforces
// the header length (pad or truncate), appends even parity, drops packets
// the router cannot route. Optional build macro ROUTER_INGRESS_STATS_EN
// adds saturating pkt_cnt / drop_cnt outputs.
//
// state       | meaning
// ST_IDLE     | one dead cycle before accepting a header
// ST_HDR      | waiting for the header beat
// ST_PLD      | forwarding payload beats
// ST_PAD      | source ended early, inserting 8'h00 up to len
// ST_DISCARD  | dropped packet, swallowing source beats through s_last
// ST_DTAIL    | len reached, swallowing surplus source beats through s_last
// ST_PAR      | parity byte queued or waiting to be taken
// ST_GAP      | router parity-check idle time
module router_pkt_ingress
  import router_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  input  logic        busy,
  output logic        pkt_valid,
  output logic [7:0]  data_in,
  output logic        len_err,
  output logic        drop
`ifdef ROUTER_INGRESS_STATS_EN
  ,
  output logic [15:0] pkt_cnt,
  output logic [15:0] drop_cnt
`endif
);

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] w_count_inc;
  logic [7:0]       r_parity;
  logic [3:0]       r_gap_cnt;
  logic             r_par_ld;
  logic             r_len_err;
  logic             r_drop;

  logic             w_full;
  logic [7:0]       w_hold_data;
  logic             w_hold_pv;
  logic             w_take;
  logic             w_room;
  logic             w_load;
  logic [7:0]       w_load_data;
  logic             w_load_pv;
  logic             w_beat;
  logic             w_hdr_ok;
  logic             w_cnt_hit;

  assign w_room      = ~w_full | w_take;
  assign w_hdr_ok    = hdr_routable(s_data);
  assign w_count_inc = r_count + LEN_W'(1);
  assign w_cnt_hit   = (w_count_inc == r_len);

  router_hold_reg u_hold (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_load      (w_load),
    .i_load_data (w_load_data),
    .i_load_pv   (w_load_pv),
    .i_busy      (busy),
    .o_full      (w_full),
    .o_data      (w_hold_data),
    .o_pv        (w_hold_pv),
    .o_take      (w_take)
  );

  assign pkt_valid = w_full & w_hold_pv;
  assign data_in   = w_hold_data;
  assign len_err   = r_len_err;
  assign drop      = r_drop;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: w_next = ST_HDR;
      ST_HDR: begin
        if (w_beat) begin
          if (!w_hdr_ok) w_next = s_last ? ST_GAP : ST_DISCARD;
          else           w_next = s_last ? ST_PAD : ST_PLD;
        end
      end
      ST_PLD: begin
        if (w_beat) begin
          if (w_cnt_hit)   w_next = s_last ? ST_PAR : ST_DTAIL;
          else if (s_last) w_next = ST_PAD;
        end
      end
      ST_PAD:     if (w_load && w_cnt_hit) w_next = ST_PAR;
      ST_DISCARD: if (w_beat && s_last) w_next = ST_GAP;
      ST_DTAIL:   if (w_beat && s_last) w_next = ST_PAR;
      // Parity may already have gone out while the surplus tail drained.
      ST_PAR:     if (r_par_ld && w_room) w_next = ST_GAP;
      ST_GAP:     if (r_gap_cnt == 4'd0) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Source handshake and hold-register load selection.
  always_comb begin
    s_ready     = 1'b0;
    w_load      = 1'b0;
    w_load_data = s_data;
    w_load_pv   = 1'b1;
    case (r_state)
      ST_HDR, ST_PLD:      s_ready = w_room;
      ST_DISCARD, ST_DTAIL: s_ready = 1'b1;
      default: ;
    endcase
    w_beat = s_valid & s_ready;
    case (r_state)
      ST_HDR: w_load = w_beat & w_hdr_ok;
      ST_PLD: w_load = w_beat;
      ST_PAD: begin
        w_load      = w_room;
        w_load_data = 8'h00;
      end
      // Parity follows the last payload byte without a bubble, even while
      // the surplus tail is still being swallowed.
      ST_DTAIL, ST_PAR: begin
        w_load      = w_room & ~r_par_ld;
        w_load_data = r_parity;
        w_load_pv   = 1'b0;
      end
      default: ;
    endcase
  end

  // Packet bookkeeping: length, byte count, running parity, status pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_len     <= '0;
      r_count   <= '0;
      r_parity  <= 8'h00;
      r_par_ld  <= 1'b0;
      r_len_err <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      r_drop    <= 1'b0;
      case (r_state)
        ST_HDR: begin
          if (w_beat) begin
            if (w_hdr_ok) begin
              r_len     <= hdr_len(s_data);
              r_count   <= '0;
              r_parity  <= s_data;
              r_par_ld  <= 1'b0;
              r_len_err <= s_last;
            end else begin
              r_drop <= 1'b1;
            end
          end
        end
        ST_PLD: begin
          if (w_beat) begin
            r_parity  <= r_parity ^ s_data;
            r_count   <= w_count_inc;
            r_len_err <= w_cnt_hit ^ s_last;
          end
        end
        ST_PAD:           if (w_load) r_count <= w_count_inc;
        ST_DTAIL, ST_PAR: if (w_load) r_par_ld <= 1'b1;
        default: ;
      endcase
    end
  end

  // Gap timer: down-counter loaded on entry to ST_GAP.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_gap_cnt <= 4'd0;
    end else if ((w_next == ST_GAP) && (r_state != ST_GAP)) begin
      r_gap_cnt <= 4'(GAP_CYCLES - 1);
    end else if (r_gap_cnt != 4'd0) begin
      r_gap_cnt <= r_gap_cnt - 4'd1;
    end
  end

`ifdef ROUTER_INGRESS_STATS_EN
  logic [15:0] r_pkt_cnt;
  logic [15:0] r_drop_cnt;

  assign pkt_cnt  = r_pkt_cnt;
  assign drop_cnt = r_drop_cnt;

  // Saturating counters of delivered parity bytes and drop pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pkt_cnt  <= 16'h0000;
      r_drop_cnt <= 16'h0000;
    end else begin
      if (w_take && !w_hold_pv && (r_pkt_cnt != 16'hFFFF)) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if (r_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_router_pkt_ingress.sv
// Bench for router_pkt_ingress: directed packets from the test plan, then
// randomized packets with random router busy, checked against a packet-level
// model of what the router should receive.
module tb_router_pkt_ingress;

  localparam int G = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic       busy = 1'b0;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       len_err;
  logic       drop;
`ifdef ROUTER_INGRESS_STATS_EN
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;
`endif

  always #5 clock = ~clock;

  router_pkt_ingress #(.GAP_CYCLES(G)) dut (
    .clock     (clock),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .busy      (busy),
    .pkt_valid (pkt_valid),
    .data_in   (data_in),
    .len_err   (len_err),
    .drop      (drop)
`ifdef ROUTER_INGRESS_STATS_EN
    ,
    .pkt_cnt   (pkt_cnt),
    .drop_cnt  (drop_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] rx_q[$];
  logic [7:0] rx_par;
  bit         par_seen = 0;
  bit         in_pkt = 0;
  int         cyc = 0;
  int         last_idx = 0;
  int         t_par = 0;
  int         n_lerr = 0;
  int         n_drop = 0;
  int         busy_pct = 0;
  int         bp_cnt = 0;
  bit         prev_gap_ok = 0;
  int         exp_pkts = 0;
  int         exp_drops = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, then observe just after it what
  // the router will do at the coming rising edge.
  task automatic tick(input logic v, input logic [7:0] d, input logic l,
                      input logic bz, input logic rst, output logic beat);
    @(negedge clock);
    reset = rst; s_valid = v; s_data = d; s_last = l; busy = bz;
    #1;
    beat = v && s_ready && !rst;
    if (!busy) begin
      if (pkt_valid) begin
        rx_q.push_back(data_in);
        in_pkt = 1;
      end else if (in_pkt) begin
        rx_par   = data_in;
        par_seen = 1;
        in_pkt   = 0;
        t_par    = cyc;
      end
    end
    if (len_err) n_lerr++;
    if (drop) n_drop++;
    last_idx = cyc;
    cyc++;
  endtask

  task automatic run_pkt(input logic [7:0] hdr, input logic [7:0] pl[$], input bit bp_req);
    logic [7:0] src[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_par;
    int n, len, m, exp_lerr, exp_drp, idle;
    bit routable, done, bp_done, gap_chk, forced;
    logic beat, bz;

    n = pl.size();
    len = int'(hdr[7:2]);
    routable = (hdr[1:0] != 2'd3) && (len != 0);
    src.push_back(hdr);
    foreach (pl[i]) src.push_back(pl[i]);

    exp_par = 8'h00; exp_lerr = 0; exp_drp = 0;
    if (routable) begin
      m = (n < len) ? n : len;
      exp_q.push_back(hdr);
      for (int i = 0; i < m; i++) exp_q.push_back(pl[i]);
      for (int i = m; i < len; i++) exp_q.push_back(8'h00);
      foreach (exp_q[i]) exp_par ^= exp_q[i];
      exp_lerr = (n != len) ? 1 : 0;
    end else begin
      exp_drp = 1;
    end

    rx_q.delete(); par_seen = 0; n_lerr = 0; n_drop = 0;
    gap_chk = prev_gap_ok; done = 0; bp_done = 0; idle = 0;

    for (int k = 0; k < 800 && !done; k++) begin
      forced = (bp_cnt > 0);
      if (forced) begin
        bz = 1'b1;
        bp_cnt--;
      end else begin
        bz = ($urandom_range(99) < busy_pct);
      end
      if (src.size() > 0) tick(1'b1, src[0], src.size() == 1, bz, 1'b0, beat);
      else                tick(1'b0, 8'h00, 1'b0, bz, 1'b0, beat);
      if (forced) begin
        chk("bp_hold_data", data_in, exp_q[1]);
        chk("bp_ready_low", s_ready, 1'b0);
      end
      if (beat) begin
        if (gap_chk && src.size() == n + 1) chk("gap_cycles", last_idx - t_par, G + 2);
        void'(src.pop_front());
      end
      if (bp_req && !bp_done && rx_q.size() == 1) begin
        bp_cnt = 4;
        bp_done = 1;
      end
      if (routable) done = (src.size() == 0) && par_seen;
      else if (src.size() == 0) begin
        idle++;
        done = (idle > G + 3);
      end
    end

    chk("pkt_done", done, 1'b1);
    chk("rx_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) chk("rx_byte", rx_q[i], exp_q[i]);
    chk("parity_seen", par_seen, routable);
    if (routable) chk("parity", rx_par, exp_par);
    chk("len_err_pulses", n_lerr, exp_lerr);
    chk("drop_pulses", n_drop, exp_drp);
    if (routable) exp_pkts++;
    else exp_drops++;
    prev_gap_ok = routable && (n <= len) && done;
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] hdr;
    logic beat;
    int len, n;

    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, beat);
    chk("rst_pkt_valid", pkt_valid, 1'b0);
    chk("rst_data_in", data_in, 8'h00);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_len_err", len_err, 1'b0);
    chk("rst_drop", drop, 1'b0);

    busy_pct = 0;
    pl = '{8'h11, 8'h22, 8'h33};
    run_pkt(8'h0D, pl, 1'b0);
    run_pkt(8'h0D, pl, 1'b1);
    pl = '{8'h11, 8'h22};
    run_pkt(8'h0D, pl, 1'b0);
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_pkt(8'h09, pl, 1'b0);
    pl = '{8'h55};
    run_pkt(8'h0F, pl, 1'b0);
    chk("drop_data_in_kept", data_in, 8'h3A);
    chk("drop_no_pkt_valid", pkt_valid, 1'b0);

    // Reset in the middle of a payload, then a clean packet.
    do tick(1'b1, 8'h0D, 1'b0, 1'b0, 1'b0, beat); while (!beat && last_idx < 2000);
    do tick(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, beat); while (!beat && last_idx < 2000);
    tick(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, beat);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, beat);
    chk("midrst_pkt_valid", pkt_valid, 1'b0);
    chk("midrst_data_in", data_in, 8'h00);
    chk("midrst_s_ready", s_ready, 1'b0);
    chk("midrst_len_err", len_err, 1'b0);
    in_pkt = 0; prev_gap_ok = 0; exp_pkts = 0; exp_drops = 0;
    pl = '{8'h11, 8'h22, 8'h33};
    run_pkt(8'h0D, pl, 1'b0);

    pl.delete();
    for (int i = 0; i < 63; i++) pl.push_back(8'($urandom));
    run_pkt(8'hFE, pl, 1'b0);

    busy_pct = 30;
    for (int p = 0; p < 40; p++) begin
      len = ($urandom_range(9) == 9) ? 63 : int'($urandom_range(8));
      n   = (len == 63) ? 61 + int'($urandom_range(4)) : int'($urandom_range(len + 2));
      hdr = {6'(len), 2'($urandom_range(3))};
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      run_pkt(hdr, pl, 1'b0);
    end

`ifdef ROUTER_INGRESS_STATS_EN
    chk("stat_pkt_cnt", pkt_cnt, exp_pkts);
    chk("stat_drop_cnt", drop_cnt, exp_drops);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
